dcache_snoop_responder: RTL and testbench

// - Cache-side end of the coherence protocol: the responder that answers bus snoops issued by the coherence controller.
// - One instance per dcache. Looks up ccsnoopaddr in the local tag/state arrays and reports a dirty (M) hit on ccwrite.
// - On a dirty hit, supplies the block as two words on dstore, paced by dwait. Then downgrades M->S, or invalidates on ccinv.
// - Clears the local LL/SC link on invalidation of the linked block. Stalls the local cache FSM while busy.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/snoop_tag_match.sv | 28 ++
 rtl/dcache_snoop_responder.sv | 146 ++++++++++++++
 tb/tb_dcache_snoop_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared dcache types: cache geometry, snoop responder states and address fields.
package cpu_types_pkg;

   localparam int SETS  = 8;
   localparam int WAYS  = 2;
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - IDX_W - 3;

   typedef enum logic [1:0] {IDLE, LOOKUP, SEND0, SEND1} snoop_state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic             word;
      logic [1:0]       byte_off;
   } dcache_addr_t;

endpackage

// File: rtl/snoop_tag_match.sv
// Combinational two-way tag compare for the snooped address; lowest way wins on a double hit.
module snoop_tag_match
   import cpu_types_pkg::*;
(
   input  logic [TAG_W-1:0]      tag,
   input  logic [WAYS*TAG_W-1:0] way_tag,
   input  logic [WAYS-1:0]       way_valid,
   input  logic [WAYS-1:0]       way_dirty,
   output logic                  hit,
   output logic                  hit_way,
   output logic                  hit_dirty
);

   logic [WAYS-1:0] way_hit;

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         way_hit[w] = way_valid[w] && (way_tag[w*TAG_W +: TAG_W] == tag);
      end
   end

   always_comb begin
      hit       = |way_hit;
      hit_way   = !way_hit[0] && way_hit[1];
      hit_dirty = hit && way_dirty[hit_way];
   end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Answers coherence snoops for one dcache: flags dirty hits, streams the block
// out in two beats, then downgrades or invalidates the line.
module dcache_snoop_responder
   import cpu_types_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ccwait,
   input  logic                  ccinv,
   input  logic [31:0]           ccsnoopaddr,
   input  logic                  dwait,
   output logic                  ccwrite,
   output logic [31:0]           dstore,
   output logic                  snoop_active,
   input  logic [WAYS*TAG_W-1:0] way_tag,
   input  logic [WAYS-1:0]       way_valid,
   input  logic [WAYS-1:0]       way_dirty,
   input  logic [WAYS*64-1:0]    way_data,
   output logic                  st_we,
   output logic                  st_way,
   output logic [IDX_W-1:0]      st_idx,
   output logic                  st_valid,
   output logic                  st_dirty,
   input  logic                  link_valid,
   input  logic [31:0]           link_addr,
   output logic                  link_clear
);

   snoop_state_t     state;
   logic [IDX_W-1:0] lat_idx;
   logic             lat_way;
   logic             lat_dirty;
   logic             inv_pend;

   dcache_addr_t     snoop_addr;
   logic             hit, hit_way, hit_dirty;
   logic             idle_inv;
   logic [63:0]      blk;
   logic             unused_bits;

   assign snoop_addr  = dcache_addr_t'(ccsnoopaddr);
   assign unused_bits = ^{snoop_addr.word, snoop_addr.byte_off, link_addr[2:0]};

   snoop_tag_match u_match (
      .tag       (snoop_addr.tag),
      .way_tag   (way_tag),
      .way_valid (way_valid),
      .way_dirty (way_dirty),
      .hit       (hit),
      .hit_way   (hit_way),
      .hit_dirty (hit_dirty)
   );

   // The array port stays on ccsnoopaddr for the whole snoop, so the latched way selects the block.
   assign blk = lat_way ? way_data[127:64] : way_data[63:0];

   assign idle_inv = ccinv && hit && ((state == IDLE) || (state == LOOKUP && !lat_dirty));

   always_comb begin
      ccwrite      = 1'b0;
      dstore       = '0;
      st_we        = 1'b0;
      st_way       = 1'b0;
      st_idx       = '0;
      st_valid     = 1'b0;
      st_dirty     = 1'b0;
      snoop_active = (state != IDLE) || ccwait || ccinv;
      unique case (state)
         LOOKUP: ccwrite = lat_dirty;
         SEND0: begin
            ccwrite = 1'b1;
            dstore  = blk[31:0];
         end
         SEND1: begin
            ccwrite = 1'b1;
            dstore  = blk[63:32];
            if (!dwait) begin
               st_we    = 1'b1;
               st_way   = lat_way;
               st_idx   = lat_idx;
               st_valid = !(inv_pend || ccinv);
            end
         end
         default: ;
      endcase
      if (idle_inv) begin
         st_we    = 1'b1;
         st_way   = hit_way;
         st_idx   = snoop_addr.idx;
         st_valid = 1'b0;
      end
      // Reset suppresses every output so an aborted transfer never writes state.
      if (RST) begin
         ccwrite      = 1'b0;
         dstore       = '0;
         snoop_active = 1'b0;
         st_we        = 1'b0;
         st_way       = 1'b0;
         st_idx       = '0;
         st_valid     = 1'b0;
      end
   end

   assign link_clear = st_we && !st_valid && link_valid &&
                       (link_addr[31:3] == ccsnoopaddr[31:3]);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         lat_idx   <= '0;
         lat_way   <= 1'b0;
         lat_dirty <= 1'b0;
         inv_pend  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ccwait) begin
                  state     <= LOOKUP;
                  lat_idx   <= snoop_addr.idx;
                  lat_way   <= hit_way;
                  lat_dirty <= hit_dirty;
                  inv_pend  <= 1'b0;
               end
            end
            LOOKUP: begin
               state    <= lat_dirty ? SEND0 : IDLE;
               inv_pend <= lat_dirty && ccinv;
            end
            SEND0: begin
               inv_pend <= inv_pend || ccinv;
               if (!dwait) state <= SEND1;
            end
            SEND1: begin
               if (!dwait) begin
                  state    <= IDLE;
                  inv_pend <= 1'b0;
               end else begin
                  inv_pend <= inv_pend || ccinv;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: bench-owned cache arrays plus a transaction-level snoop model.
module tb_dcache_snoop_responder;
   import cpu_types_pkg::*;

   logic                  CLK = 1'b0;
   logic                  RST, ccwait, ccinv, dwait, link_valid;
   logic [31:0]           ccsnoopaddr, link_addr, dstore;
   logic                  ccwrite, snoop_active, st_we, st_way, st_valid, st_dirty, link_clear;
   logic [IDX_W-1:0]      st_idx;
   logic [WAYS*TAG_W-1:0] way_tag;
   logic [WAYS-1:0]       way_valid, way_dirty;
   logic [WAYS*64-1:0]    way_data;

   always #5 CLK = ~CLK;

   dcache_snoop_responder dut (
      .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .dwait(dwait), .ccwrite(ccwrite), .dstore(dstore), .snoop_active(snoop_active),
      .way_tag(way_tag), .way_valid(way_valid), .way_dirty(way_dirty), .way_data(way_data),
      .st_we(st_we), .st_way(st_way), .st_idx(st_idx), .st_valid(st_valid), .st_dirty(st_dirty),
      .link_valid(link_valid), .link_addr(link_addr), .link_clear(link_clear)
   );

   // Cache contents owned by the bench
   logic [TAG_W-1:0] a_tag   [SETS][WAYS];
   bit               a_valid [SETS][WAYS];
   bit               a_dirty [SETS][WAYS];
   logic [31:0]      a_word  [SETS][WAYS][2];

   int checks = 0, failures = 0;

   // Snoop transaction model: busy, in its lookup cycle, or sending beat m_beat
   bit m_busy, m_lookup, m_beat, m_dirty, m_way, m_inv;
   int m_idx;
   bit n_busy, n_lookup, n_beat, n_dirty, n_way, n_inv;
   int n_idx;
   bit e_act, e_ccw, e_we, e_way, e_valid, e_lc;
   int e_idx;
   logic [31:0] e_dst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_addr(input int tag, input int idx);
      return (32'(tag) << (IDX_W + 3)) | (32'(idx) << 3);
   endfunction

   task automatic drive_arrays();
      int idx = int'((ccsnoopaddr >> 3) & (SETS - 1));
      for (int w = 0; w < WAYS; w++) begin
         way_tag[w*TAG_W +: TAG_W] = a_tag[idx][w];
         way_valid[w]              = a_valid[idx][w];
         way_dirty[w]              = a_dirty[idx][w];
         way_data[w*64 +: 64]      = {a_word[idx][w][1], a_word[idx][w][0]};
      end
   endtask

   task automatic clear_arrays();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            a_tag[s][w] = '0; a_valid[s][w] = 0; a_dirty[s][w] = 0;
            a_word[s][w][0] = '0; a_word[s][w][1] = '0;
         end
   endtask

   task automatic set_line(input int idx, input int w, input int tag, input bit v, input bit d,
                           input logic [31:0] w0, input logic [31:0] w1);
      a_tag[idx][w] = TAG_W'(tag); a_valid[idx][w] = v; a_dirty[idx][w] = d;
      a_word[idx][w][0] = w0; a_word[idx][w][1] = w1;
   endtask

   task automatic model_eval();
      int idx = int'((ccsnoopaddr >> 3) & (SETS - 1));
      logic [TAG_W-1:0] tag = ccsnoopaddr[31:32-TAG_W];
      bit hit = 0;
      bit hw = 0;
      bit sending = m_busy && !m_lookup;
      for (int w = WAYS - 1; w >= 0; w--)
         if (a_valid[idx][w] && a_tag[idx][w] == tag) begin hit = 1; hw = w[0]; end
      e_act = m_busy || ccwait || ccinv;
      e_ccw = (m_lookup && m_dirty) || sending;
      e_dst = sending ? a_word[m_idx][m_way][m_beat] : 32'h0;
      e_we = 0; e_way = 0; e_idx = 0; e_valid = 0;
      if (ccinv && hit && (!m_busy || (m_lookup && !m_dirty))) begin
         e_we = 1; e_way = hw; e_idx = idx; e_valid = 0;
      end
      if (sending && m_beat && !dwait) begin
         e_we = 1; e_way = m_way; e_idx = m_idx; e_valid = !(m_inv || ccinv);
      end
      if (RST) begin
         e_act = 0; e_ccw = 0; e_dst = 0; e_we = 0;
      end
      e_lc = e_we && !e_valid && link_valid && (link_addr[31:3] == ccsnoopaddr[31:3]);
      n_busy = m_busy; n_lookup = m_lookup; n_beat = m_beat; n_dirty = m_dirty;
      n_way = m_way; n_inv = m_inv; n_idx = m_idx;
      if (RST) begin
         n_busy = 0; n_lookup = 0; n_beat = 0; n_inv = 0;
      end else if (!m_busy) begin
         if (ccwait) begin
            n_busy = 1; n_lookup = 1; n_dirty = hit && a_dirty[idx][hw];
            n_way = hw; n_idx = idx; n_inv = 0;
         end
      end else if (m_lookup) begin
         n_lookup = 0; n_beat = 0; n_inv = ccinv;
         if (!m_dirty) n_busy = 0;
      end else begin
         n_inv = m_inv || ccinv;
         if (!dwait) begin
            if (m_beat) n_busy = 0;
            else n_beat = 1;
         end
      end
   endtask

   task automatic compare();
      chk("snoop_active", snoop_active, e_act);
      chk("ccwrite", ccwrite, e_ccw);
      chk("dstore", dstore, e_dst);
      chk("st_we", st_we, e_we);
      chk("link_clear", link_clear, e_lc);
      if (e_we) begin
         chk("st_way", st_way, e_way);
         chk("st_idx", st_idx, e_idx);
         chk("st_valid", st_valid, e_valid);
         chk("st_dirty", st_dirty, 0);
      end
   endtask

   task automatic settle();
      drive_arrays();
      #2;
   endtask

   task automatic tick();
      model_eval();
      compare();
      @(posedge CLK);
      m_busy = n_busy; m_lookup = n_lookup; m_beat = n_beat; m_dirty = n_dirty;
      m_way = n_way; m_inv = n_inv; m_idx = n_idx;
      if (e_we) begin
         a_valid[e_idx][e_way] = e_valid;
         a_dirty[e_idx][e_way] = 0;
      end
      #1;
   endtask

   task automatic cyc();
      settle();
      tick();
   endtask

   initial begin
      logic [31:0] addr;
      int t0;
      RST = 1; ccwait = 0; ccinv = 0; dwait = 0; link_valid = 0; link_addr = 0;
      ccsnoopaddr = 0;
      m_busy = 0; m_lookup = 0; m_beat = 0; m_dirty = 0; m_way = 0; m_inv = 0; m_idx = 0;
      clear_arrays();
      cyc(); cyc();
      RST = 0;
      settle();
      chk("rst_ccwrite", ccwrite, 0); chk("rst_dstore", dstore, 0);
      chk("rst_active", snoop_active, 0); chk("rst_st_we", st_we, 0);
      tick();

      // Dirty hit way1 idx3 with two wait cycles on beat 0
      set_line(3, 1, 5, 1, 1, 32'hA0A0_0000, 32'hB1B1_0001);
      ccsnoopaddr = mk_addr(5, 3);
      ccwait = 1; settle();
      chk("s1_act_t0", snoop_active, 1); chk("s1_ccw_t0", ccwrite, 0); tick();
      ccwait = 0; settle();
      chk("s1_ccw_t1", ccwrite, 1); chk("s1_dst_t1", dstore, 0); tick();
      dwait = 1; settle(); chk("s1_w0_t2", dstore, 32'hA0A0_0000); tick();
      settle(); chk("s1_w0_t3", dstore, 32'hA0A0_0000); tick();
      dwait = 0; settle(); chk("s1_w0_t4", dstore, 32'hA0A0_0000); tick();
      settle();
      chk("s1_w1", dstore, 32'hB1B1_0001); chk("s1_we", st_we, 1); chk("s1_way", st_way, 1);
      chk("s1_idx", st_idx, 3); chk("s1_v", st_valid, 1); chk("s1_d", st_dirty, 0);
      tick();
      settle(); chk("s1_act_end", snoop_active, 0); chk("s1_ccw_end", ccwrite, 0); tick();

      // Clean hit, invalidate two cycles after the snoop
      set_line(2, 0, 7, 1, 0, 32'h1111_1111, 32'h2222_2222);
      ccsnoopaddr = mk_addr(7, 2);
      ccwait = 1; cyc();
      ccwait = 0; settle(); chk("s2_ccw_t1", ccwrite, 0); tick();
      ccinv = 1; settle();
      chk("s2_we", st_we, 1); chk("s2_v", st_valid, 0); chk("s2_way", st_way, 0);
      chk("s2_idx", st_idx, 2); chk("s2_ccw", ccwrite, 0); tick();
      ccinv = 0; cyc();

      // Miss: no write and no link clear
      ccsnoopaddr = mk_addr(9, 2); link_valid = 1; link_addr = ccsnoopaddr;
      ccwait = 1; cyc();
      ccwait = 0; settle(); chk("s3_ccw", ccwrite, 0); tick();
      ccinv = 1; settle();
      chk("s3_we", st_we, 0); chk("s3_lc", link_clear, 0); chk("s3_ccw2", ccwrite, 0); tick();
      ccinv = 0; link_valid = 0; cyc();

      // Dirty hit with invalidate during the second beat clears the link
      set_line(4, 0, 3, 1, 1, 32'hC0C0_C0C0, 32'hC1C1_C1C1);
      addr = mk_addr(3, 4); ccsnoopaddr = addr;
      link_valid = 1; link_addr = addr ^ 32'h4;
      ccwait = 1; cyc();
      ccwait = 0; cyc();
      settle(); chk("s4_w0", dstore, 32'hC0C0_C0C0); tick();
      ccinv = 1; settle();
      chk("s4_w1", dstore, 32'hC1C1_C1C1); chk("s4_we", st_we, 1); chk("s4_v", st_valid, 0);
      chk("s4_d", st_dirty, 0); chk("s4_lc", link_clear, 1); tick();
      ccinv = 0; link_valid = 0; cyc();

      // Reset in the middle of beat 0 aborts, then a fresh snoop completes
      set_line(5, 1, 2, 1, 1, 32'hD0D0_0000, 32'hD1D1_0000);
      ccsnoopaddr = mk_addr(2, 5);
      ccwait = 1; cyc();
      ccwait = 0; cyc();
      dwait = 1; RST = 1; cyc();
      RST = 0; dwait = 0; settle();
      chk("s5_ccw", ccwrite, 0); chk("s5_dst", dstore, 0); chk("s5_we", st_we, 0);
      chk("s5_act", snoop_active, 0); tick();
      ccwait = 1; cyc();
      ccwait = 0; settle(); chk("s5_ccw_again", ccwrite, 1); tick();
      settle(); chk("s5_w0", dstore, 32'hD0D0_0000); tick();
      settle(); chk("s5_w1", dstore, 32'hD1D1_0000); chk("s5_we2", st_we, 1); tick();

      // Snoop pulsed during the second beat is ignored
      set_line(6, 0, 1, 1, 1, 32'hE0E0_0000, 32'hE1E1_0000);
      ccsnoopaddr = mk_addr(1, 6);
      ccwait = 1; cyc();
      ccwait = 0; cyc();
      cyc();
      dwait = 1; ccwait = 1; settle();
      chk("s6_w1", dstore, 32'hE1E1_0000); chk("s6_we_hold", st_we, 0); tick();
      dwait = 0; ccwait = 0; settle(); chk("s6_we", st_we, 1); tick();
      settle(); chk("s6_act", snoop_active, 0); chk("s6_ccw", ccwrite, 0); tick();
      settle(); chk("s6_ccw2", ccwrite, 0); chk("s6_dst", dstore, 0); tick();

      // Randomized traffic against the model
      for (int s = 0; s < SETS; s++) begin
         t0 = $urandom_range(0, 3);
         set_line(s, 0, t0, 1'($urandom), 0, $urandom, $urandom);
         set_line(s, 1, (t0 + $urandom_range(1, 3)) % 4, 1'($urandom), 0, $urandom, $urandom);
         for (int w = 0; w < WAYS; w++) a_dirty[s][w] = a_valid[s][w] && 1'($urandom);
      end
      for (int i = 0; i < 3000; i++) begin
         RST = ($urandom_range(0, 199) == 0);
         if (!m_busy) begin
            if ($urandom_range(0, 9) == 0) begin
               int s = $urandom_range(0, SETS - 1);
               int w = $urandom_range(0, WAYS - 1);
               a_valid[s][w] = 1; a_dirty[s][w] = 1;
            end
            ccsnoopaddr = mk_addr($urandom_range(0, 4), $urandom_range(0, SETS - 1)) | ($urandom & 32'h7);
         end
         ccwait = ($urandom_range(0, 3) == 0);
         ccinv  = ($urandom_range(0, 7) == 0);
         dwait  = ($urandom_range(0, 2) == 0);
         link_valid = 1'($urandom);
         case ($urandom_range(0, 2))
            0: link_addr = ccsnoopaddr;
            1: link_addr = ccsnoopaddr ^ 32'h4;
            default: link_addr = $urandom;
         endcase
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
